// File: rtl/connect_feeder_pkg.sv
// Shared constants and state encoding for the fully-connected stage feeder.
package connect_feeder_pkg;

    localparam int FEAT_BYTES = 27;
    localparam int WIN_CYC    = 9;
    localparam int VEC_W      = 216;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_FETCH,
        ST_LOAD,
        ST_DRIVE,
        ST_WAIT
    } feeder_state_t;

endpackage

// File: rtl/connect_feeder_if.sv
// Bus between the feeder (master) and connect_module (slave).
interface connect_feeder_if;
    import connect_feeder_pkg::*;

    logic [VEC_W-1:0] pool_lin;
    logic [VEC_W-1:0] weight_lin;
    logic             fc_in_vld;
    logic [7:0]       fc_ans;
    logic             fc_out_vld;

    modport master (
        output pool_lin,
        output weight_lin,
        output fc_in_vld,
        input  fc_ans,
        input  fc_out_vld
    );

    modport slave (
        input  pool_lin,
        input  weight_lin,
        input  fc_in_vld,
        output fc_ans,
        output fc_out_vld
    );

endinterface

// File: rtl/connect_feeder_pack_buf.sv
// 27-byte packing register: byte k of the stream lands in data[k*8 +: 8].
// full pulses combinationally while the last byte of a set is being taken.
module feeder_pack_buf
    import connect_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [7:0]       in_data,
    output logic [VEC_W-1:0] data,
    output logic             full
);

    logic [CNT_W-1:0] count;

    assign full = in_vld && (count == CNT_W'(FEAT_BYTES - 1));

    // Store each accepted byte at the slot given by the running count, wrap after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
        end else if (in_vld) begin
            data[{count, 3'b000} +: 8] <= in_data;
            count <= full ? '0 : count + 5'd1;
        end
    end

endmodule

// File: rtl/connect_feeder.sv
// Sequencer that collects pooled features and walks connect_module through
// every output neuron, fetching weights and forwarding indexed results.
module connect_feeder
    import connect_feeder_pkg::*;
#(
    parameter int NUM_OUT  = 10,
    parameter int IDX_W    = 4,
    parameter int WAIT_MAX = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              px_vld,
    input  logic [7:0]        px_data,
    output logic              px_rdy,
    output logic [IDX_W-1:0]  wt_addr,
    input  logic [VEC_W-1:0]  wt_data,
    connect_feeder_if.master  fc,
    output logic              res_vld,
    output logic [7:0]        res_data,
    output logic [IDX_W-1:0]  res_idx,
    output logic              res_err,
    output logic              busy
);

    localparam int WT_W = $clog2(WAIT_MAX + 1);

    feeder_state_t    state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       drv_cnt;
    logic [WT_W-1:0]  wait_cnt;
    logic [VEC_W-1:0] pool_q;
    logic [VEC_W-1:0] weight_q;
    logic             fc_vld_q;
    logic             byte_take;
    logic             buf_full;
    logic             neuron_done;

    assign byte_take     = px_vld & px_rdy;
    assign wt_addr       = idx;
    assign fc.pool_lin   = pool_q;
    assign fc.weight_lin = weight_q;
    assign fc.fc_in_vld  = fc_vld_q;
    assign neuron_done   = fc.fc_out_vld || (wait_cnt == WT_W'(WAIT_MAX - 1));

    feeder_pack_buf u_pack (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (byte_take),
        .in_data (px_data),
        .data    (pool_q),
        .full    (buf_full)
    );

    // Main sequencer: fill, then per neuron fetch weights, drive the 9-cycle window and collect the answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FILL;
            idx      <= '0;
            drv_cnt  <= '0;
            wait_cnt <= '0;
            weight_q <= '0;
            fc_vld_q <= 1'b0;
            px_rdy   <= 1'b1;
            busy     <= 1'b0;
            res_vld  <= 1'b0;
            res_data <= '0;
            res_idx  <= '0;
            res_err  <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            res_err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (buf_full) begin
                        state  <= ST_FETCH;
                        px_rdy <= 1'b0;
                        busy   <= 1'b1;
                        idx    <= '0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    weight_q <= wt_data;
                    fc_vld_q <= 1'b1;
                    drv_cnt  <= '0;
                    state    <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (drv_cnt == 4'(WIN_CYC - 1)) begin
                        fc_vld_q <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end else begin
                        drv_cnt <= drv_cnt + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (neuron_done) begin
                        res_vld  <= 1'b1;
                        res_idx  <= idx;
                        res_err  <= !fc.fc_out_vld;
                        res_data <= fc.fc_out_vld ? fc.fc_ans : 8'h00;
                        if (idx == IDX_W'(NUM_OUT - 1)) begin
                            state  <= ST_FILL;
                            px_rdy <= 1'b1;
                            busy   <= 1'b0;
                            idx    <= '0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_FETCH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_connect_feeder.sv
// Self-checking bench for connect_feeder: directed feature sets, a connect_module
// stand-in, a result scoreboard and per-cycle protocol checks.
module tb_connect_feeder;

    localparam int NUM_OUT  = 10;
    localparam int IDX_W    = 4;
    localparam int WAIT_MAX = 63;
    localparam int RESP_LAT = 3;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
        logic             err;
        int               delta;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             px_vld;
    logic [7:0]       px_data;
    logic             px_rdy;
    logic [IDX_W-1:0] wt_addr;
    logic [215:0]     wt_data;
    logic             res_vld;
    logic [7:0]       res_data;
    logic [IDX_W-1:0] res_idx;
    logic             res_err;
    logic             busy;

    connect_feeder_if fc ();

    connect_feeder #(
        .NUM_OUT  (NUM_OUT),
        .IDX_W    (IDX_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .px_vld   (px_vld),
        .px_data  (px_data),
        .px_rdy   (px_rdy),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .fc       (fc),
        .res_vld  (res_vld),
        .res_data (res_data),
        .res_idx  (res_idx),
        .res_err  (res_err),
        .busy     (busy)
    );

    int           checks;
    int           failures;
    int           cyc;
    int           win_end;
    int           mode;
    int           silent_idx;
    int           spur_en;
    int           resp_n;
    bit           started;
    logic [215:0] rom [16];
    logic [7:0]   stim [27];
    exp_t         expq [$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        wt_data <= rom[wt_addr];
    end

    task automatic checkOutput(input string name, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [215:0] packStim();
        logic [215:0] v;
        v = '0;
        for (int k = 0; k < 27; k++) v[k*8 +: 8] = stim[k];
        return v;
    endfunction

    function automatic logic [7:0] modelDot(input logic [215:0] f, input logic [215:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 27; k++) s += int'(f[k*8 +: 8]) * int'(w[k*8 +: 8]);
        return 8'(s);
    endfunction

    task automatic pushResults();
        exp_t e;
        for (int n = 0; n < NUM_OUT; n++) begin
            e.idx = IDX_W'(n);
            e.err = 1'b0;
            e.delta = RESP_LAT + 1;
            if (mode == 0) e.data = modelDot(packStim(), rom[n]);
            else e.data = 8'(n * 3);
            if (n == silent_idx) begin
                e.data = 8'h00;
                e.err = 1'b1;
                e.delta = WAIT_MAX;
            end
            expq.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit gap);
        int b;
        for (int k = 0; k < 27; k++) begin
            b = 0;
            while (!px_rdy && b < 100) begin
                @(negedge clk);
                b++;
            end
            checkOutput("px_rdy_fill", {215'd0, px_rdy}, 216'd1);
            px_vld = 1'b1;
            px_data = stim[k];
            @(negedge clk);
            if (gap) begin
                px_vld = 1'b0;
                @(negedge clk);
            end
        end
        px_vld = 1'b0;
    endtask

    task automatic waitIdle();
        int b;
        b = 0;
        while ((expq.size() != 0 || busy) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        checkOutput("idle_reached", {215'd0, (expq.size() == 0 && !busy)}, 216'd1);
        repeat (3) @(negedge clk);
    endtask

    // connect_module stand-in: measures the input window and answers after a fixed latency.
    initial begin : responder
        int           win_len;
        int           pend;
        logic [7:0]   pend_ans;
        logic [215:0] snap_pool;
        logic [215:0] snap_wt;
        bit           stable_ok;
        win_len = 0;
        pend = 0;
        pend_ans = '0;
        snap_pool = '0;
        snap_wt = '0;
        stable_ok = 1'b1;
        fc.fc_out_vld = 1'b0;
        fc.fc_ans = '0;
        forever begin
            @(negedge clk);
            fc.fc_out_vld = 1'b0;
            if (rst) begin
                win_len = 0;
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        fc.fc_out_vld = 1'b1;
                        fc.fc_ans = pend_ans;
                    end
                end
                if (spur_en != 0 && fc.fc_in_vld && win_len == 4) begin
                    fc.fc_out_vld = 1'b1;
                    fc.fc_ans = 8'hEE;
                end
                if (fc.fc_in_vld) begin
                    if (win_len == 0) begin
                        snap_pool = fc.pool_lin;
                        snap_wt = fc.weight_lin;
                        stable_ok = 1'b1;
                        checkOutput("weight_lin", fc.weight_lin, rom[resp_n]);
                    end else if (fc.pool_lin !== snap_pool || fc.weight_lin !== snap_wt) begin
                        stable_ok = 1'b0;
                    end
                    win_len++;
                end else if (win_len > 0) begin
                    checkOutput("win_len", 216'(win_len), 216'd9);
                    checkOutput("win_stable", {215'd0, stable_ok}, 216'd1);
                    if (resp_n != silent_idx) begin
                        pend = RESP_LAT;
                        pend_ans = (mode == 0) ? modelDot(snap_pool, snap_wt) : 8'(resp_n * 3);
                    end
                    resp_n++;
                    win_len = 0;
                end
            end
        end
    end

    // Per-cycle compare: result scoreboard with timing, plus ready/busy exclusivity.
    initial begin : compare
        bit   prev_fcv;
        exp_t e;
        prev_fcv = 1'b0;
        cyc = 0;
        win_end = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_fcv && !fc.fc_in_vld) win_end = cyc;
            prev_fcv = fc.fc_in_vld;
            if (started) begin
                checkOutput("rdy_vs_busy", {215'd0, px_rdy}, {215'd0, !busy});
                if (res_vld) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL res_unexpected actual idx=%0d data=%0h required no strobe", res_idx, res_data);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("res_idx", 216'(res_idx), 216'(e.idx));
                        checkOutput("res_data", 216'(res_data), 216'(e.data));
                        checkOutput("res_err", 216'(res_err), 216'(e.err));
                        checkOutput("res_delay", 216'(cyc - win_end), 216'(e.delta));
                        if (e.idx == IDX_W'(NUM_OUT - 1)) begin
                            checkOutput("px_rdy_last", {215'd0, px_rdy}, 216'd1);
                            checkOutput("busy_last", {215'd0, busy}, 216'd0);
                        end
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin : stimulus
        int b;
        checks = 0;
        failures = 0;
        started = 1'b0;
        mode = 0;
        silent_idx = -1;
        spur_en = 0;
        resp_n = 0;
        rst = 1'b1;
        px_vld = 1'b0;
        px_data = '0;
        for (int n = 0; n < 16; n++) rom[n] = {27{8'h01}};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_px_rdy", {215'd0, px_rdy}, 216'd1);
        checkOutput("rst_busy", {215'd0, busy}, 216'd0);
        checkOutput("rst_fc_in_vld", {215'd0, fc.fc_in_vld}, 216'd0);
        checkOutput("rst_res_vld", {215'd0, res_vld}, 216'd0);
        checkOutput("rst_pool_lin", fc.pool_lin, 216'd0);
        checkOutput("rst_weight_lin", fc.weight_lin, 216'd0);
        started = 1'b1;

        $display("[TB] test 1: bytes 1..27, unit weights, dot-product answers");
        for (int k = 0; k < 27; k++) stim[k] = 8'(k + 1);
        mode = 0;
        resp_n = 0;
        pushResults();
        expq[0].data = 8'h7A;
        applyStimulus(1'b0);
        checkOutput("t1_pool_lin", fc.pool_lin, packStim());
        checkOutput("t1_pool_b26", 216'(fc.pool_lin[215:208]), 216'h1B);
        waitIdle();

        $display("[TB] test 2: indexed answers idx*3");
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < 27; k++) rom[n][k*8 +: 8] = 8'(n * 17 + k);
        for (int k = 0; k < 27; k++) stim[k] = 8'(k * 7 + 3);
        mode = 1;
        resp_n = 0;
        pushResults();
        applyStimulus(1'b0);
        checkOutput("t2_pool_b0", 216'(fc.pool_lin[7:0]), 216'h03);
        checkOutput("t2_pool_lin", fc.pool_lin, packStim());
        waitIdle();

        $display("[TB] test 3: gapped stream and byte offered while busy");
        for (int k = 0; k < 27; k++) stim[k] = 8'(k + 1);
        mode = 0;
        resp_n = 0;
        pushResults();
        applyStimulus(1'b1);
        px_vld = 1'b1;
        px_data = 8'hFF;
        @(negedge clk);
        px_vld = 1'b0;
        checkOutput("t3_pool_lin", fc.pool_lin, packStim());
        checkOutput("t3_pool_b26", 216'(fc.pool_lin[215:208]), 216'h1B);
        waitIdle();
        checkOutput("t3_pool_after", fc.pool_lin, packStim());

        $display("[TB] test 4: neuron 2 never answers");
        for (int k = 0; k < 27; k++) stim[k] = 8'(k * 13 + 5);
        mode = 1;
        silent_idx = 2;
        resp_n = 0;
        pushResults();
        applyStimulus(1'b0);
        checkOutput("t4_pool_lin", fc.pool_lin, packStim());
        waitIdle();
        silent_idx = -1;

        $display("[TB] test 5: spurious strobe during the input window");
        for (int k = 0; k < 27; k++) stim[k] = 8'(200 - k);
        mode = 1;
        spur_en = 1;
        resp_n = 0;
        pushResults();
        applyStimulus(1'b0);
        waitIdle();
        spur_en = 0;

        $display("[TB] test 6: reset on the fifth drive cycle");
        for (int k = 0; k < 27; k++) stim[k] = 8'(k + 40);
        mode = 1;
        resp_n = 0;
        applyStimulus(1'b0);
        b = 0;
        while (!fc.fc_in_vld && b < 50) begin
            @(negedge clk);
            b++;
        end
        checkOutput("t6_drive_seen", {215'd0, fc.fc_in_vld}, 216'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_fc_in_vld", {215'd0, fc.fc_in_vld}, 216'd0);
        checkOutput("t6_pool_lin", fc.pool_lin, 216'd0);
        checkOutput("t6_px_rdy", {215'd0, px_rdy}, 216'd1);
        checkOutput("t6_res_vld", {215'd0, res_vld}, 216'd0);
        @(negedge clk);
        rst = 1'b0;
        resp_n = 0;
        repeat (80) @(negedge clk);
        checkOutput("t6_idle_rdy", {215'd0, px_rdy}, 216'd1);
        checkOutput("t6_idle_busy", {215'd0, busy}, 216'd0);
        checkOutput("queue_empty", 216'(expq.size()), 216'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
